// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID/EX stage bus; ID_EX_STAT_EN adds the stall/flush statistics counters.
interface id_ex_stage_if #(parameter int XLEN = 32, parameter int REG_AW = 5);
  logic              stall_i, flush_i, valid_i, pred_taken_i;
  logic [31:0]       instr_i;
  logic [XLEN-1:0]   pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic              valid_o, pred_taken_o, illegal_o;
  logic [XLEN-1:0]   pc_o, alu_in0_o, alu_in1_o, rs2_data_o;
  logic [2:0]        alu_op_o;
  logic [REG_AW-1:0] rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic              reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_o;
`ifdef ID_EX_STAT_EN
  logic [31:0]       stall_cnt_o, flush_cnt_o;
`endif
  modport master (
    output stall_i, flush_i, valid_i, pred_taken_i, instr_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
    input  valid_o, pred_taken_o, illegal_o, pc_o, alu_in0_o, alu_in1_o, rs2_data_o, alu_op_o,
           rs1_addr_o, rs2_addr_o, rd_addr_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_o
`ifdef ID_EX_STAT_EN
    , input stall_cnt_o, flush_cnt_o
`endif
  );
  modport slave (
    input  stall_i, flush_i, valid_i, pred_taken_i, instr_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
    output valid_o, pred_taken_o, illegal_o, pc_o, alu_in0_o, alu_in1_o, rs2_data_o, alu_op_o,
           rs1_addr_o, rs2_addr_o, rd_addr_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_o
`ifdef ID_EX_STAT_EN
    , output stall_cnt_o, flush_cnt_o
`endif
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32 ID/EX pipeline register with decode, stall hold and flush bubble; ID_EX_STAT_EN adds counters.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input logic          clk_i,
  input logic          rst_i,
  id_ex_stage_if.slave bus
);
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc, rs1, rs2, imm;
    logic [2:0]        op;
    logic [REG_AW-1:0] a1, a2, rd;
    logic              src, rw, mr, mw, m2r, br, pt, ill;
  } ex_t;
  ex_t q, dec, bub;
  logic [6:0] op7, f7;
  logic [2:0] f3;
  logic [8:0] dc;
  logic       ill;
  assign op7 = bus.instr_i[6:0];
  assign f3  = bus.instr_i[14:12];
  assign f7  = bus.instr_i[31:25];
  // dc = {alu_op, alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch}
  always_comb begin
    ill = 1'b0;
    casez ({f7, f3, op7})
      17'b0000000_000_0110011: dc = {3'b000, 6'b010000};
      17'b0100000_000_0110011: dc = {3'b001, 6'b010000};
      17'b0000001_000_0110011: dc = {3'b010, 6'b010000};
      17'b0000000_111_0110011: dc = {3'b100, 6'b010000};
      17'b0000000_100_0110011: dc = {3'b101, 6'b010000};
      17'b0000000_001_0110011: dc = {3'b110, 6'b010000};
      17'b???????_000_0010011: dc = {3'b000, 6'b110000};
      17'b0100000_101_0010011: dc = {3'b111, 6'b110000};
      17'b???????_010_0000011: dc = {3'b000, 6'b111010};
      17'b???????_010_0100011: dc = {3'b000, 6'b100100};
      17'b???????_000_1100011: dc = {3'b001, 6'b000001};
      default: begin
        dc  = {3'b011, 6'b000000};
        ill = 1'b1;
      end
    endcase
  end
  always_comb begin
    bub    = '0;
    bub.op = 3'b011;
    dec    = '0;
    dec.valid = 1'b1;
    dec.pc    = bus.pc_i;
    dec.rs1   = bus.rs1_data_i;
    dec.rs2   = bus.rs2_data_i;
    dec.imm   = bus.imm_i;
    dec.a1    = REG_AW'(bus.instr_i[19:15]);
    dec.a2    = REG_AW'(bus.instr_i[24:20]);
    dec.rd    = REG_AW'(bus.instr_i[11:7]);
    {dec.op, dec.src, dec.rw, dec.mr, dec.mw, dec.m2r, dec.br} = dc;
    dec.pt    = bus.pred_taken_i;
    dec.ill   = ill;
  end
  always_ff @(posedge clk_i)
    if (rst_i || bus.flush_i) q <= bub;
    else if (!bus.stall_i)    q <= bus.valid_i ? dec : bub;
  assign bus.valid_o      = q.valid;
  assign bus.pc_o         = q.pc;
  assign bus.alu_op_o     = q.op;
  assign bus.alu_in0_o    = q.rs1;
  assign bus.alu_in1_o    = q.src ? q.imm : q.rs2;
  assign bus.rs2_data_o   = q.rs2;
  assign bus.rs1_addr_o   = q.a1;
  assign bus.rs2_addr_o   = q.a2;
  assign bus.rd_addr_o    = q.rd;
  assign bus.reg_write_o  = q.rw;
  assign bus.mem_read_o   = q.mr;
  assign bus.mem_write_o  = q.mw;
  assign bus.mem_to_reg_o = q.m2r;
  assign bus.branch_o     = q.br;
  assign bus.pred_taken_o = q.pt;
  assign bus.illegal_o    = q.ill;
`ifdef ID_EX_STAT_EN
  logic [31:0] stall_cnt, flush_cnt;
  // Both counters stick at all-ones rather than wrapping
  always_ff @(posedge clk_i)
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.flush_i && ~&flush_cnt)                  flush_cnt <= flush_cnt + 32'd1;
      if (bus.stall_i && !bus.flush_i && ~&stall_cnt) stall_cnt <= stall_cnt + 32'd1;
    end
  assign bus.stall_cnt_o = stall_cnt;
  assign bus.flush_cnt_o = flush_cnt;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed-vector bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;
  logic clk = 1'b0, rst = 1'b1;
  int   errs = 0, checks = 0;
  always #5 clk = ~clk;
  id_ex_stage_if #(.XLEN(32), .REG_AW(5)) bus ();
  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] ins, pc, r1, r2, imm, input logic pt);
    bus.valid_i = v;  bus.instr_i = ins;  bus.pc_i = pc;
    bus.rs1_data_i = r1;  bus.rs2_data_i = r2;  bus.imm_i = imm;  bus.pred_taken_i = pt;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_bubble(input string tag);
    check({tag, ".valid"}, 32'(bus.valid_o), 0);
    check({tag, ".op"}, 32'(bus.alu_op_o), 32'd3);
    check({tag, ".pc"}, bus.pc_o, 0);
    check({tag, ".in0"}, bus.alu_in0_o, 0);
    check({tag, ".in1"}, bus.alu_in1_o, 0);
    check({tag, ".rs2d"}, bus.rs2_data_o, 0);
    check({tag, ".addr"}, 32'({bus.rs1_addr_o, bus.rs2_addr_o, bus.rd_addr_o}), 0);
    check({tag, ".ctl"}, 32'({bus.reg_write_o, bus.mem_read_o, bus.mem_write_o, bus.mem_to_reg_o, bus.branch_o}), 0);
    check({tag, ".pt_ill"}, 32'({bus.pred_taken_o, bus.illegal_o}), 0);
  endtask
  initial begin
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    drive(1'b1, $urandom, $urandom, $urandom, $urandom, $urandom, 1'b1);
    tick;
    drive(1'b1, $urandom, $urandom, $urandom, $urandom, $urandom, 1'b1);
    bus.stall_i = 1'b1;
    tick;
    check_bubble("reset");
    rst = 1'b0;
    bus.stall_i = 1'b0;
    // sub x3,x1,x2
    drive(1'b1, 32'h402081B3, 32'h100, 32'd7, 32'd5, 32'h77, 1'b1);
    tick;
    check("sub.valid", 32'(bus.valid_o), 1);
    check("sub.op", 32'(bus.alu_op_o), 32'd1);
    check("sub.in0", bus.alu_in0_o, 7);
    check("sub.in1", bus.alu_in1_o, 5);
    check("sub.addr", 32'({bus.rs1_addr_o, bus.rs2_addr_o, bus.rd_addr_o}), 32'({5'd1, 5'd2, 5'd3}));
    check("sub.ctl", 32'({bus.reg_write_o, bus.mem_read_o, bus.mem_write_o, bus.mem_to_reg_o, bus.branch_o}), 32'b10000);
    check("sub.pc", bus.pc_o, 32'h100);
    check("sub.pt_ill", 32'({bus.pred_taken_o, bus.illegal_o}), 32'b10);
    // srai x5,x6,3
    drive(1'b1, 32'h40335293, 32'h104, 32'd11, 32'd9, 32'h403, 1'b0);
    tick;
    check("srai.op", 32'(bus.alu_op_o), 32'd7);
    check("srai.in1", bus.alu_in1_o, 32'h403);
    check("srai.rs2d", bus.rs2_data_o, 9);
    check("srai.rd", 32'(bus.rd_addr_o), 5);
    check("srai.rw", 32'(bus.reg_write_o), 1);
    // and x1,x2,x3
    drive(1'b1, 32'h003170B3, 32'h108, 32'd1, 32'd2, 32'd3, 1'b0);
    tick;
    check("and.op", 32'(bus.alu_op_o), 32'd4);
    check("and.in1", bus.alu_in1_o, 2);
    // lw x4,8(x2) then a 3-cycle stall with different inputs
    drive(1'b1, 32'h00812203, 32'h10C, 32'h1000, 32'd6, 32'd8, 1'b0);
    tick;
    check("lw.ctl", 32'({bus.reg_write_o, bus.mem_read_o, bus.mem_write_o, bus.mem_to_reg_o, bus.branch_o}), 32'b11010);
    check("lw.in1", bus.alu_in1_o, 8);
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h402081B3, 32'h200 + i, 32'hDEAD, 32'hBEEF, 32'h1, 1'b1);
      tick;
      check($sformatf("stall%0d.mr", i), 32'(bus.mem_read_o), 1);
      check($sformatf("stall%0d.pc", i), bus.pc_o, 32'h10C);
      check($sformatf("stall%0d.in0", i), bus.alu_in0_o, 32'h1000);
      check($sformatf("stall%0d.op", i), 32'(bus.alu_op_o), 0);
    end
    // sw x5,12(x2) on the first unstalled edge
    bus.stall_i = 1'b0;
    drive(1'b1, 32'h00512623, 32'h110, 32'h2000, 32'h55, 32'd12, 1'b0);
    tick;
    check("sw.ctl", 32'({bus.reg_write_o, bus.mem_read_o, bus.mem_write_o, bus.mem_to_reg_o, bus.branch_o}), 32'b00100);
    check("sw.in1", bus.alu_in1_o, 12);
    check("sw.rs2d", bus.rs2_data_o, 32'h55);
    check("sw.pc", bus.pc_o, 32'h110);
    // flush wins over stall
    bus.stall_i = 1'b1;
    bus.flush_i = 1'b1;
    drive(1'b1, 32'h402081B3, 32'h114, 32'd1, 32'd1, 32'd1, 1'b1);
    tick;
    check_bubble("flush_stall");
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    // beq x1,x2 uses rs2, not the immediate
    drive(1'b1, 32'h00208063, 32'h118, 32'd4, 32'd9, 32'h40, 1'b1);
    tick;
    check("beq.op", 32'(bus.alu_op_o), 32'd1);
    check("beq.ctl", 32'({bus.reg_write_o, bus.mem_read_o, bus.mem_write_o, bus.mem_to_reg_o, bus.branch_o}), 32'b00001);
    check("beq.in1", bus.alu_in1_o, 9);
    check("beq.pt", 32'(bus.pred_taken_o), 1);
    // illegal encoding
    drive(1'b1, 32'hFFFFFFFF, 32'h11C, 32'd1, 32'd2, 32'd3, 1'b0);
    tick;
    check("ill.flag", 32'(bus.illegal_o), 1);
    check("ill.op", 32'(bus.alu_op_o), 32'd3);
    check("ill.ctl", 32'({bus.reg_write_o, bus.mem_read_o, bus.mem_write_o, bus.mem_to_reg_o, bus.branch_o}), 0);
    check("ill.valid", 32'(bus.valid_o), 1);
    // invalid slot loads a bubble
    drive(1'b0, 32'h402081B3, 32'h120, 32'd1, 32'd2, 32'd3, 1'b1);
    tick;
    check_bubble("novalid");
    // reset overrides stall
    drive(1'b1, 32'h402081B3, 32'h124, 32'd1, 32'd2, 32'd3, 1'b1);
    tick;
    check("pre_rst.valid", 32'(bus.valid_o), 1);
    rst = 1'b1;
    bus.stall_i = 1'b1;
    tick;
    check_bubble("rst_stall");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
